// File: rtl/div_pkg.sv
// Shared definitions for the divider request sequencer: state encoding, operand
// width default and the {remainder, quotient} field layout.
package div_pkg;

    localparam int DATA_W_DEFAULT = 4;

    // {remainder, quotient} layout of div_result and result_out
    localparam int QUOT_LSB = 0;
    localparam int REM_LSB  = DATA_W_DEFAULT;

    localparam logic [2*DATA_W_DEFAULT-1:0] DIV0_RESULT = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_CHECK    = 3'd2,
        S_START    = 3'd3,
        S_WAIT     = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/go_debounce.sv
// Counts consecutive high samples of go_raw while armed and flags the sample that
// completes a valid press.
module go_debounce
    import div_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic go_raw,
    input  logic arm,
    output logic accept
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] deb_cnt;

    // A low sample or leaving the armed states restarts the count from zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            deb_cnt <= '0;
        end else if (!arm || !go_raw || (deb_cnt == DEB_LAST)) begin
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign accept = arm && go_raw && (deb_cnt == DEB_LAST);

endmodule

// File: rtl/div_request_sequencer.sv
// Front end for the 4-bit restoring divider: debounced request, operand freeze,
// divide-by-zero screen, start pulse, timeout supervision and result capture.
//
//   state      | meaning
//   S_IDLE     | waiting for go_raw; flags and result hold
//   S_DEBOUNCE | counting consecutive high go_raw samples
//   S_CHECK    | flags cleared; divisor screened for zero
//   S_START    | div_start high for this one cycle
//   S_WAIT     | waiting for div_done, bounded by the timeout counter
//   S_RELEASE  | waiting for go_raw to drop before re-arming
module div_request_sequencer
    import div_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                go_raw,
    input  logic [2*DATA_W-1:0] operands_in,
    input  logic                div_done,
    input  logic [2*DATA_W-1:0] div_result,
    output logic                div_start,
    output logic [2*DATA_W-1:0] div_operands,
    output logic [2*DATA_W-1:0] result_out,
    output logic                result_valid,
    output logic                busy,
    output logic                div_by_zero,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    to_cnt, to_cnt_d;
    logic [2*DATA_W-1:0] operands_d, result_d;
    logic                valid_d, div0_d, timeout_d;
    logic                deb_arm, deb_accept;

    assign deb_arm = (state_q == S_IDLE) || (state_q == S_DEBOUNCE);

    go_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_go_debounce (
        .clk   (clk),
        .resetn(resetn),
        .go_raw(go_raw),
        .arm   (deb_arm),
        .accept(deb_accept)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt;
        operands_d = div_operands;
        result_d   = result_out;
        valid_d    = result_valid;
        div0_d     = div_by_zero;
        timeout_d  = timeout_err;

        case (state_q)
            S_IDLE: begin
                if (go_raw) begin
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!go_raw) begin
                    state_d = S_IDLE;
                end else if (deb_accept) begin
                    operands_d = operands_in;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                valid_d   = 1'b0;
                div0_d    = 1'b0;
                timeout_d = 1'b0;
                if (div_operands[DATA_W-1:0] == '0) begin
                    result_d = '1;
                    div0_d   = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Completion on the terminal count still counts as success.
                if (div_done) begin
                    result_d = div_result;
                    valid_d  = 1'b1;
                    state_d  = S_RELEASE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!go_raw) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt       <= '0;
            div_operands <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            div_by_zero  <= 1'b0;
            timeout_err  <= 1'b0;
            div_start    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            to_cnt       <= to_cnt_d;
            div_operands <= operands_d;
            result_out   <= result_d;
            result_valid <= valid_d;
            div_by_zero  <= div0_d;
            timeout_err  <= timeout_d;
            div_start    <= (state_d == S_START);
            busy         <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_div_request_sequencer.sv
// Randomized and directed bench for div_request_sequencer against a press/transaction
// model kept in the bench.
module tb_div_request_sequencer;

    localparam int D = 16;
    localparam int T = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go_raw;
    logic [7:0] operands_in;
    logic       div_done;
    logic [7:0] div_result;
    logic       div_start;
    logic [7:0] div_operands;
    logic [7:0] result_out;
    logic       result_valid;
    logic       busy;
    logic       div_by_zero;
    logic       timeout_err;

    div_request_sequencer #(
        .DATA_W         (4),
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .go_raw      (go_raw),
        .operands_in (operands_in),
        .div_done    (div_done),
        .div_result  (div_result),
        .div_start   (div_start),
        .div_operands(div_operands),
        .result_out  (result_out),
        .result_valid(result_valid),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 25)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase of the current press/transaction.
    // 0 idle, 1 counting press, 2 screening divisor, 3 start pulse, 4 core running, 5 awaiting release
    int         m_phase = 0;
    int         m_press = 0;
    int         m_waited = 0;
    logic [7:0] m_ops = '0, m_res = '0;
    bit         m_valid = 0, m_dz = 0, m_to = 0;

    always @(posedge clk) begin
        cyc++;
        if (!resetn) begin
            m_phase = 0; m_press = 0; m_waited = 0;
            m_ops = '0; m_res = '0; m_valid = 0; m_dz = 0; m_to = 0;
        end else begin
            case (m_phase)
                0: if (go_raw) begin m_phase = 1; m_press = 1; end
                1: begin
                    if (!go_raw) m_phase = 0;
                    else begin
                        m_press++;
                        if (m_press == D) begin m_ops = operands_in; m_phase = 2; end
                    end
                end
                2: begin
                    m_valid = 0; m_dz = 0; m_to = 0;
                    if (m_ops[3:0] == 4'd0) begin
                        m_res = 8'hFF; m_dz = 1; m_valid = 1; m_phase = 5;
                    end else m_phase = 3;
                end
                3: begin m_phase = 4; m_waited = 0; end
                4: begin
                    m_waited++;
                    if (div_done) begin m_res = div_result; m_valid = 1; m_phase = 5; end
                    else if (m_waited == T) begin m_to = 1; m_phase = 5; end
                end
                default: if (!go_raw) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("div_start",    32'(div_start),    32'(m_phase == 3));
            chk("busy",         32'(busy),         32'(m_phase != 0));
            chk("div_operands", 32'(div_operands), 32'(m_ops));
            chk("result_out",   32'(result_out),   32'(m_res));
            chk("result_valid", 32'(result_valid), 32'(m_valid));
            chk("div_by_zero",  32'(div_by_zero),  32'(m_dz));
            chk("timeout_err",  32'(timeout_err),  32'(m_to));
        end
    end

    // Core stand-in: div_done core_lat cycles after div_start (0 = never answers).
    int         core_lat = 0;
    logic [7:0] core_res = '0;
    bit         spur_en = 0;
    int         cd = 0;

    always @(negedge clk) begin
        div_done   = 1'b0;
        div_result = 8'($urandom);
        if (div_start) begin
            cd = core_lat;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin div_done = 1'b1; div_result = core_res; end
        end
        if (spur_en && ($urandom_range(0, 3) == 0)) div_done = 1'b1;
    end

    int  starts = 0;
    int  start_cyc = 0;
    int  to_rise_cyc = 0;
    bit  prev_to = 0;

    always @(negedge clk) begin
        if (div_start) begin starts++; start_cyc = cyc; end
        if (timeout_err && !prev_to) to_rise_cyc = cyc;
        prev_to = timeout_err;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] ops, input int hold, input int idle);
        operands_in = ops;
        go_raw = 1'b1;
        cycles(hold);
        go_raw = 1'b0;
        cycles(idle);
    endtask

    int s0;
    logic [7:0] keep;

    initial begin
        resetn = 1'b0; go_raw = 1'b0; operands_in = '0;
        cycles(3);
        chk_en = 1'b1;
        chk("reset outputs", {div_start, busy, result_valid, div_by_zero, timeout_err, div_operands, result_out}, '0);
        resetn = 1'b1;
        cycles(2);

        // normal division, button held past acceptance
        s0 = starts; core_lat = 18; core_res = 8'h12;
        press(8'h73, 20, 50);
        chk("t1 starts", starts - s0, 1);
        chk("t1 operands", div_operands, 8'h73);
        chk("t1 result", result_out, 8'h12);
        chk("t1 model result", m_res, 8'h12);
        chk("t1 flags", {result_valid, div_by_zero, timeout_err}, 3'b100);

        // short press rejected
        s0 = starts;
        press(8'h21, 5, 10);
        chk("t2 starts", starts - s0, 0);
        chk("t2 busy", busy, 0);
        chk("t2 result held", {result_valid, result_out}, {1'b1, 8'h12});

        // divide by zero
        s0 = starts;
        press(8'h50, 20, 10);
        chk("t3 starts", starts - s0, 0);
        chk("t3 result", {result_valid, div_by_zero, result_out}, {2'b11, 8'hFF});
        chk("t3 model result", {m_valid, m_dz, m_res}, {2'b11, 8'hFF});

        // silent core -> timeout; rises on the edge after the 32nd waiting cycle
        core_lat = 0;
        press(8'h93, 20, 60);
        chk("t4 timeout", {timeout_err, result_valid, div_by_zero}, 3'b100);
        chk("t4 timeout latency", to_rise_cyc - start_cyc, T + 1);
        core_lat = 5; core_res = 8'h03;
        press(8'h62, 20, 30);
        chk("t4 cleared", {timeout_err, result_valid, result_out}, {2'b01, 8'h03});

        // done on terminal count wins; one later is a timeout
        core_lat = T; core_res = 8'h2A;
        press(8'hE5, 20, 60);
        chk("t5 done at limit", {timeout_err, result_valid, result_out}, {2'b01, 8'h2A});
        core_lat = T + 1;
        press(8'hE5, 20, 60);
        chk("t5 one past limit", {timeout_err, result_valid}, 2'b10);
        core_lat = 4; core_res = 8'h31;
        press(8'h97, 20, 30);
        keep = result_out;
        spur_en = 1;
        cycles(30);
        spur_en = 0;
        chk("t5 spurious done", {result_valid, result_out}, {1'b1, keep});

        // reset in the middle of a wait, button kept down afterwards
        core_lat = 0;
        operands_in = 8'hB3;
        go_raw = 1'b1;
        cycles(25);
        resetn = 1'b0;
        cycles(1);
        resetn = 1'b1;
        chk("t6 reset outputs", {div_start, busy, result_valid, div_by_zero, timeout_err, div_operands, result_out}, '0);
        s0 = starts; core_lat = 5; core_res = 8'h23;
        cycles(200);
        go_raw = 1'b0;
        cycles(5);
        chk("t6 single start", starts - s0, 1);
        chk("t6 result", result_out, 8'h23);

        // random traffic
        for (int it = 0; it < 250; it++) begin
            core_lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
            core_res = 8'($urandom);
            spur_en  = ($urandom_range(0, 7) == 0);
            operands_in = 8'($urandom);
            if ($urandom_range(0, 3) == 0) operands_in[3:0] = 4'd0;
            go_raw = 1'b1;
            for (int c = $urandom_range(1, 30); c > 0; c--) begin
                if ($urandom_range(0, 3) == 0) operands_in = 8'($urandom);
                if ($urandom_range(0, 150) == 0) resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
            end
            go_raw = 1'b0;
            cycles(($urandom_range(0, 4) == 0) ? 60 : $urandom_range(0, 6));
        end
        spur_en = 0;
        cycles(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
